soma_comp_serial: RTL and testbench

Parametrised, multi-cycle two's-complement adder/subtractor for the lab datapath. It processes `DIGIT` bits per clock from LSB to MSB through one shared digit slice, trading latency for area. A start/busy/done handshake controls it. It produces sum/difference, carry-out and signed overflow, and holds the result until the next operation completes.

---
 rtl/soma_comp_pkg.sv | 15 +
 rtl/soma_digit.sv | 23 ++
 rtl/soma_comp_serial.sv | 106 ++++++++++
 tb/tb_soma_comp_serial.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/soma_comp_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
package soma_comp_pkg;

  typedef enum logic [1:0] {SC_IDLE, SC_BUSY, SC_DONE} sc_state_t;

  function automatic logic sc_ovf(input logic a_msb, input logic b_msb_eff, input logic s_msb);
    return (a_msb == b_msb_eff) && (s_msb != a_msb);
  endfunction

  // Step counter width able to hold 0..n
  function automatic int sc_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/soma_digit.sv
// Combinational DIGIT-bit ripple-carry slice shared by every step.
module soma_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum[i] = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/soma_comp_serial.sv
// Digit-serial two's-complement add/sub: WIDTH/DIGIT cycles per op, LSB first,
// with start/busy/done handshake and result registers held between completions.
module soma_comp_serial
  import soma_comp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = sc_cnt_w(N);

  sc_state_t        state, state_nx;
  logic [WIDTH-1:0] opa, opb, part_nx;
  logic [CW-1:0]    cnt;
  logic             carry, sub_q, a_msb, b_msb;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             accept, last;

  assign busy   = (state == SC_BUSY);
  assign done   = (state == SC_DONE);
  assign accept = start && !busy;
  assign last   = busy && (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SC_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SC_IDLE: if (start) state_nx = SC_BUSY;
      SC_BUSY: if (last)  state_nx = SC_DONE;
      SC_DONE: state_nx = start ? SC_BUSY : SC_IDLE;
      default: state_nx = SC_IDLE;
    endcase
  end

  soma_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (opa[DIGIT-1:0]),
    .y    (opb[DIGIT-1:0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout)
  );

  // Partial result fills from the MSB end; with a single digit there is nothing to hold.
  if (N > 1) begin : g_shift
    logic [WIDTH-DIGIT-1:0] part;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       part <= '0;
      else if (busy) part <= part_nx[WIDTH-1:DIGIT];
    end
    assign part_nx = {dsum, part};
  end else begin : g_one
    assign part_nx = dsum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sub_q <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
      sub_q <= sub;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (busy) begin
      opa   <= opa >> DIGIT;
      opb   <= opb >> DIGIT;
      carry <= dcout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        s    <= part_nx;
        cout <= dcout;
        ovf  <= sc_ovf(a_msb, b_msb ^ sub_q, part_nx[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_soma_comp_serial.sv
// Scoreboard bench: two instances (4/1 and 8/2), directed vectors, decoupled monitors.
module tb_soma_comp_serial;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- WIDTH=4, DIGIT=1 ----------------
  logic       rst4 = 1'b1, start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       busy4, done4, cout4, ovf4;

  soma_comp_serial #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
  );

  // ---------------- WIDTH=8, DIGIT=2 ----------------
  logic       rst8 = 1'b1, start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       busy8, done8, cout8, ovf8;

  soma_comp_serial #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  exp_t q4[$], q8[$];
  exp_t last4 = '{s: 8'h0, cout: 1'b0, ovf: 1'b0, due: 0};
  exp_t last8 = '{s: 8'h0, cout: 1'b0, ovf: 1'b0, due: 0};
  int   bc4 = 0, bc8 = 0;

  always @(negedge clk) begin
    if (rst4) begin
      q4.delete();
      last4 = '{s: 8'h0, cout: 1'b0, ovf: 1'b0, due: 0};
      bc4 = 0;
    end else begin
      if (busy4) bc4++;
      if (done4) begin
        if (q4.size() == 0) check("w4_spurious_done", int'(done4), 0);
        else begin
          exp_t e;
          e = q4.pop_front();
          check("w4_s", int'(s4), int'(e.s));
          check("w4_cout", int'(cout4), int'(e.cout));
          check("w4_ovf", int'(ovf4), int'(e.ovf));
          check("w4_latency", cyc, e.due);
          check("w4_busy_cycles", bc4, 4);
          check("w4_busy_in_done", int'(busy4), 0);
          last4 = e;
        end
        bc4 = 0;
      end else
        check("w4_hold", int'({s4, cout4, ovf4}), int'({last4.s[3:0], last4.cout, last4.ovf}));
    end
  end

  always @(negedge clk) begin
    if (rst8) begin
      q8.delete();
      last8 = '{s: 8'h0, cout: 1'b0, ovf: 1'b0, due: 0};
      bc8 = 0;
    end else begin
      if (busy8) bc8++;
      if (done8) begin
        if (q8.size() == 0) check("w8_spurious_done", int'(done8), 0);
        else begin
          exp_t e;
          e = q8.pop_front();
          check("w8_s", int'(s8), int'(e.s));
          check("w8_cout", int'(cout8), int'(e.cout));
          check("w8_ovf", int'(ovf8), int'(e.ovf));
          check("w8_latency", cyc, e.due);
          check("w8_busy_cycles", bc8, 4);
          check("w8_busy_in_done", int'(busy8), 0);
          last8 = e;
        end
        bc8 = 0;
      end else
        check("w8_hold", int'({s8, cout8, ovf8}), int'({last8.s, last8.cout, last8.ovf}));
    end
  end

  // Start one 4-bit op; push the expectation only when it should be accepted.
  task automatic go4(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                     input logic [3:0] es, input logic ec, input logic eo, input bit push);
    @(negedge clk);
    a4 = ta; b4 = tb; sub4 = ts; start4 = 1'b1;
    if (push) q4.push_back('{s: 8'(es), cout: ec, ovf: eo, due: cyc + 5});
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic drain4();
    for (int i = 0; i < 40 && q4.size() != 0; i++) @(negedge clk);
    check("w4_timeout", q4.size(), 0);
  endtask

  task automatic drain8();
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
    check("w8_timeout", q8.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("w4_rst_busy", int'(busy4), 0);
    check("w4_rst_outs", int'({done4, s4, cout4, ovf4}), 0);
    check("w8_rst_busy", int'(busy8), 0);
    check("w8_rst_outs", int'({done8, s8, cout8, ovf8}), 0);
    rst4 = 1'b0; rst8 = 1'b0;
    @(negedge clk);

    // 4-bit directed vectors
    go4(4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0, 1); drain4();
    go4(4'b0001, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0, 1); drain4();
    go4(4'b0001, 4'b0011, 1'b1, 4'b1110, 1'b0, 1'b0, 1); drain4();
    go4(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1); drain4();
    go4(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1, 1); drain4();

    // start during BUSY with different operands must be ignored
    go4(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1);
    go4(4'b0001, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 0);
    drain4();

    // reset mid-operation: outputs clear immediately, no done follows
    go4(4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0, 1);
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    check("w4_abort_busy", int'(busy4), 0);
    check("w4_abort_outs", int'({done4, s4, cout4, ovf4}), 0);
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    repeat (8) @(negedge clk);
    go4(4'b0001, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0, 1); drain4();

    // 8-bit: carry-out wrap, then back-to-back subtract accepted in the done cycle
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back('{s: 8'h00, cout: 1'b1, ovf: 1'b0, due: cyc + 5});
    @(negedge clk);
    start8 = 1'b0;
    begin
      int k;
      for (k = 0; k < 20 && !done8; k++) @(negedge clk);
      check("w8_done_seen", int'(done8), 1);
    end
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1; start8 = 1'b1;
    q8.push_back('{s: 8'hF0, cout: 1'b0, ovf: 1'b0, due: cyc + 5});
    @(negedge clk);
    start8 = 1'b0;
    drain8();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
